// File: rtl/pong_pkg.sv
// Shared PONG definitions: UART receiver state encoding, keyboard key codes and default bit timing.
package pong_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    localparam logic [7:0] KEY_W = 8'd119;
    localparam logic [7:0] KEY_S = 8'd115;
    localparam logic [7:0] KEY_O = 8'd111;
    localparam logic [7:0] KEY_L = 8'd108;

    typedef enum logic [2:0] {
        UART_IDLE  = 3'd0,
        UART_START = 3'd1,
        UART_DATA  = 3'd2,
        UART_STOP  = 3'd3,
        UART_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value selectable per use.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_key_rx.sv
// 8N1 UART receiver for the PONG keyboard: mid-bit sampling, last good byte held on o_key_byte.
//
// state | meaning
// IDLE  | line idle high, waiting for a falling edge
// START | counting to mid start bit to confirm it is not a glitch
// DATA  | sampling 8 data bits LSB-first, one per bit period
// STOP  | sampling the stop bit; high publishes the byte, low flags a frame error
// BREAK | line stuck low after a bad frame; wait for it to return high
module uart_key_rx
    import pong_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_RX_serial,
    output logic [7:0] o_key_byte,
    output logic       o_key_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic        rst_n_int;
    logic        rx_s;

    uart_state_t state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  key_byte_q, key_byte_d;
    logic        key_valid_q, key_valid_d;
    logic        frame_err_q, frame_err_d;

    // Reset asserts immediately but releases on a clock edge.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_rst_sync (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_async (1'b1),
        .o_sync  (rst_n_int)
    );

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_CLK   (i_CLK),
        .i_RST_N (rst_n_int),
        .i_async (i_RX_serial),
        .o_sync  (rx_s)
    );

    always_ff @(posedge i_CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= UART_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            key_byte_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            key_byte_q  <= key_byte_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        key_byte_d  = key_byte_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            UART_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = UART_START;
                end
            end

            UART_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = UART_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            UART_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            UART_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        key_byte_d  = shift_q;
                        key_valid_d = 1'b1;
                        state_d     = UART_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = UART_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            UART_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = UART_IDLE;
                end
            end

            default: begin
                state_d   = UART_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    assign o_key_byte  = key_byte_q;
    assign o_key_valid = key_valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_key_rx.sv
// Directed bench for uart_key_rx at 16 clocks per bit with an ideal 8N1 line driver.
module tb_uart_key_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] key_byte;
    logic       key_valid;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic both_seen = 1'b0;
    logic long_valid = 1'b0;
    logic prev_valid = 1'b0;
    logic [7:0] rx_bytes [$];

    uart_key_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_RX_serial (rx),
        .o_key_byte  (key_byte),
        .o_key_valid (key_valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            rx_bytes.push_back(key_byte);
            if (prev_valid) long_valid = 1'b1;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (key_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
        prev_valid = (key_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge; each bit lasts exactly CPB clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
    endtask

    int v0;
    int f0;
    int n0;
    logic any_nonzero;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;

        // 1: reset state, then long idle
        idle(5);
        check("rst_byte", {24'd0, key_byte}, 32'h00);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        any_nonzero = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            idle(1);
            if (key_byte !== 8'h00 || key_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
                any_nonzero = 1'b1;
        end
        check("idle_outputs_zero", {31'd0, any_nonzero}, 32'd0);
        check("idle_no_pulses", valid_cnt + ferr_cnt, 32'd0);

        // 2: single 'w'
        v0 = valid_cnt;
        send_frame(8'h77, 1'b1);
        idle(30);
        check("w_valid_count", valid_cnt - v0, 32'd1);
        check("w_byte", {24'd0, key_byte}, 32'h77);
        check("w_latency_153_155",
              {31'd0, ((last_valid_cyc - start_cyc) >= 153 && (last_valid_cyc - start_cyc) <= 155)}, 32'd1);
        check("w_no_ferr", ferr_cnt, 32'd0);
        check("w_not_busy", {31'd0, busy}, 32'd0);

        // 3: back-to-back 's' then 'w'
        v0 = valid_cnt;
        n0 = rx_bytes.size();
        send_frame(8'h73, 1'b1);
        send_frame(8'h77, 1'b1);
        idle(30);
        check("b2b_valid_count", valid_cnt - v0, 32'd2);
        check("b2b_first", {24'd0, rx_bytes[n0]}, 32'h73);
        check("b2b_second", {24'd0, rx_bytes[n0 + 1]}, 32'h77);

        // 4: bad stop bit followed by a held-low line
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        idle(40);
        check("ferr_count", ferr_cnt - f0, 32'd1);
        check("ferr_no_valid", valid_cnt - v0, 32'd0);
        check("ferr_byte_held", {24'd0, key_byte}, 32'h77);
        check("ferr_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        idle(10);
        check("ferr_idle_after_high", {31'd0, busy}, 32'd0);
        v0 = valid_cnt;
        send_frame(8'h73, 1'b1);
        idle(30);
        check("ferr_recover_count", valid_cnt - v0, 32'd1);
        check("ferr_recover_byte", {24'd0, key_byte}, 32'h73);

        // 5: short low glitch on the idle line
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(30);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
        check("glitch_byte_held", {24'd0, key_byte}, 32'h73);
        send_frame(8'h77, 1'b1);
        idle(30);
        check("glitch_next_byte", {24'd0, key_byte}, 32'h77);

        // 6: reset in the middle of data bit 4
        v0 = valid_cnt;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            idle(CPB);
        end
        rx = 1'b1;
        idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_byte", {24'd0, key_byte}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, key_valid}, 32'd0);
        idle(3);
        rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(CPB * 12);
        check("midrst_no_pulse", valid_cnt - v0, 32'd0);
        send_frame(8'h73, 1'b1);
        idle(30);
        check("midrst_next_count", valid_cnt - v0, 32'd1);
        check("midrst_next_byte", {24'd0, key_byte}, 32'h73);

        check("valid_ferr_never_together", {31'd0, both_seen}, 32'd0);
        check("valid_single_cycle", {31'd0, long_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
